// File: rtl/imm_gen_pipe.sv
// Decode-stage immediate generator: opcode-driven format decode, XLEN sign extension,
// 2-entry valid/ready output buffer, saturating illegal-opcode counter. Option: IMM_GEN_ZICSR_EN.
module imm_gen_pipe #(
  parameter int XLEN  = 32,  // 32 or 64
  parameter int TAG_W = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag,
  output logic [CNT_W-1:0] illegal_cnt
);

  // Handshake: a beat transfers on a rising edge where valid && ready are both high;
  // in_ready depends only on the registered occupancy, and flush overrides both sides.

  localparam logic [2:0] FMT_I    = 3'b000;
  localparam logic [2:0] FMT_S    = 3'b001;
  localparam logic [2:0] FMT_B    = 3'b010;
  localparam logic [2:0] FMT_J    = 3'b011;
  localparam logic [2:0] FMT_U    = 3'b100;
  localparam logic [2:0] FMT_SH   = 3'b101;
  localparam logic [2:0] FMT_Z    = 3'b110;
  localparam logic [2:0] FMT_NONE = 3'b111;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_MISC   = 7'b0001111;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic            sign;
  logic [2:0]      dec_fmt;
  logic            dec_ill;
  logic [31:0]     imm32;
  logic [XLEN-1:0] dec_imm;

  logic [XLEN-1:0]  imm_q [2];
  logic [2:0]       fmt_q [2];
  logic             ill_q [2];
  logic [TAG_W-1:0] tag_q [2];
  logic             wr_ptr_q, rd_ptr_q;
  logic [1:0]       count_q, count_d;
  logic [CNT_W-1:0] illegal_cnt_q, illegal_cnt_d;
  logic             accept, pop;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign sign   = in_instr[31];

  // Every recognised opcode ends in 2'b11, so compressed encodings fall into default.
  always_comb begin
    dec_fmt = FMT_NONE;
    dec_ill = 1'b0;
    case (opcode)
      OPC_LOAD, OPC_JALR, OPC_MISC: dec_fmt = FMT_I;
      OPC_OPIMM:  dec_fmt = (funct3 == 3'b001 || funct3 == 3'b101) ? FMT_SH : FMT_I;
      OPC_STORE:  dec_fmt = FMT_S;
      OPC_BRANCH: dec_fmt = FMT_B;
      OPC_JAL:    dec_fmt = FMT_J;
      OPC_LUI, OPC_AUIPC: dec_fmt = FMT_U;
      OPC_OP:     dec_fmt = FMT_NONE;
      OPC_SYSTEM: begin
`ifdef IMM_GEN_ZICSR_EN
        dec_fmt = (funct3 != 3'b000) ? FMT_Z : FMT_I;
`else
        dec_fmt = FMT_I;
`endif
      end
      default:    dec_ill = 1'b1;
    endcase
  end

  // Immediates are first built at 32 bits; the XLEN stage only replicates bit 31.
  always_comb begin
    imm32 = 32'd0;
    case (dec_fmt)
      FMT_I:  imm32 = {{20{sign}}, in_instr[31:20]};
      FMT_S:  imm32 = {{20{sign}}, in_instr[31:25], in_instr[11:7]};
      FMT_B:  imm32 = {{19{sign}}, in_instr[31], in_instr[7], in_instr[30:25],
                       in_instr[11:8], 1'b0};
      FMT_J:  imm32 = {{11{sign}}, in_instr[31], in_instr[19:12], in_instr[20],
                       in_instr[30:21], 1'b0};
      FMT_U:  imm32 = {in_instr[31:12], 12'd0};
      FMT_SH: imm32 = (XLEN == 64) ? {26'd0, in_instr[25:20]} : {27'd0, in_instr[24:20]};
      FMT_Z:  imm32 = {27'd0, in_instr[19:15]};
      default: imm32 = 32'd0;
    endcase
  end

  if (XLEN == 64) begin : g_x64
    assign dec_imm = {{32{imm32[31]}}, imm32};
  end else begin : g_x32
    assign dec_imm = imm32;
  end

  assign in_ready  = (count_q < 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    count_d = count_q;
    case ({accept, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    illegal_cnt_d = illegal_cnt_q;
    if (accept && dec_ill && (illegal_cnt_q != CNT_MAX))
      illegal_cnt_d = illegal_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        imm_q[i] <= '0;
        fmt_q[i] <= 3'b000;
        ill_q[i] <= 1'b0;
        tag_q[i] <= '0;
      end
      wr_ptr_q      <= 1'b0;
      rd_ptr_q      <= 1'b0;
      count_q       <= 2'd0;
      illegal_cnt_q <= '0;
    end else if (flush) begin
      // Any same-cycle push is dropped and does not reach the illegal counter.
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (accept) begin
        imm_q[wr_ptr_q] <= dec_imm;
        fmt_q[wr_ptr_q] <= dec_fmt;
        ill_q[wr_ptr_q] <= dec_ill;
        tag_q[wr_ptr_q] <= in_tag;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      count_q       <= count_d;
      illegal_cnt_q <= illegal_cnt_d;
    end
  end

  // Head entry is read straight from storage, so it holds while stalled.
  assign out_imm     = imm_q[rd_ptr_q];
  assign out_fmt     = fmt_q[rd_ptr_q];
  assign out_illegal = ill_q[rd_ptr_q];
  assign out_tag     = tag_q[rd_ptr_q];
  assign illegal_cnt = illegal_cnt_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: instance a (XLEN 32, CNT_W 2) and instance b (XLEN 64).
module tb_imm_gen_pipe;

  localparam int W = 100;  // {imm[63:0], fmt[2:0], illegal, tag[31:0]}

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic        flush_a = 0, in_valid_a = 0, out_ready_a = 1;
  logic [31:0] in_instr_a = 0, in_tag_a = 0;
  logic        in_ready_a, out_valid_a, out_illegal_a;
  logic [31:0] out_imm_a, out_tag_a;
  logic [2:0]  out_fmt_a;
  logic [1:0]  illegal_cnt_a;

  logic        flush_b = 0, in_valid_b = 0, out_ready_b = 1;
  logic [31:0] in_instr_b = 0, in_tag_b = 0;
  logic        in_ready_b, out_valid_b, out_illegal_b;
  logic [63:0] out_imm_b;
  logic [31:0] out_tag_b;
  logic [2:0]  out_fmt_b;
  logic [15:0] illegal_cnt_b;

  logic [W-1:0] exp_a[$];
  logic [W-1:0] exp_b[$];
  int n_vec = 0;
  int n_err = 0;

  imm_gen_pipe #(.XLEN(32), .TAG_W(32), .CNT_W(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .flush(flush_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .in_instr(in_instr_a), .in_tag(in_tag_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
    .out_imm(out_imm_a), .out_fmt(out_fmt_a), .out_illegal(out_illegal_a), .out_tag(out_tag_a),
    .illegal_cnt(illegal_cnt_a));

  imm_gen_pipe #(.XLEN(64), .TAG_W(32), .CNT_W(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(flush_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_instr(in_instr_b), .in_tag(in_tag_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
    .out_imm(out_imm_b), .out_fmt(out_fmt_b), .out_illegal(out_illegal_b), .out_tag(out_tag_b),
    .illegal_cnt(illegal_cnt_b));

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h @%0t", name, act, exp, $time);
    end
  endtask

  // driver tasks: entered and left at posedge+1
  task automatic push_a(input logic [31:0] instr, input logic [31:0] tag,
                        input logic [63:0] imm, input logic [2:0] fmt, input logic ill);
    int n = 0;
    in_valid_a = 1; in_instr_a = instr; in_tag_a = tag;
    while (!in_ready_a && n < 50) begin @(posedge clk); #1; n++; end
    if (!in_ready_a) begin
      check("a_accept_timeout", 64'(in_ready_a), 64'd1);
      in_valid_a = 0;
      return;
    end
    exp_a.push_back({imm, fmt, ill, tag});
    @(posedge clk); #1;
    in_valid_a = 0;
  endtask

  task automatic push_b(input logic [31:0] instr, input logic [31:0] tag,
                        input logic [63:0] imm, input logic [2:0] fmt, input logic ill);
    int n = 0;
    in_valid_b = 1; in_instr_b = instr; in_tag_b = tag;
    while (!in_ready_b && n < 50) begin @(posedge clk); #1; n++; end
    if (!in_ready_b) begin
      check("b_accept_timeout", 64'(in_ready_b), 64'd1);
      in_valid_b = 0;
      return;
    end
    exp_b.push_back({imm, fmt, ill, tag});
    @(posedge clk); #1;
    in_valid_b = 0;
  endtask

  // unscored pushes used to fill the buffer before a flush or reset
  task automatic raw_push_a(input int n);
    in_valid_a = 1; in_instr_a = 32'h00100093; in_tag_a = 32'hDEAD;
    repeat (n) begin @(posedge clk); #1; end
    in_valid_a = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // scoreboard monitors
  always @(negedge clk) begin
    if (rst_n && out_valid_a && out_ready_a) begin
      if (exp_a.size() == 0) check("a_unexpected_out", 64'(out_tag_a), 64'hFFFF_FFFF);
      else begin
        logic [W-1:0] e;
        e = exp_a.pop_front();
        check("a_imm", 64'(out_imm_a), e[99:36]);
        check("a_fmt", 64'(out_fmt_a), 64'(e[35:33]));
        check("a_ill", 64'(out_illegal_a), 64'(e[32]));
        check("a_tag", 64'(out_tag_a), 64'(e[31:0]));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && out_valid_b && out_ready_b) begin
      if (exp_b.size() == 0) check("b_unexpected_out", 64'(out_tag_b), 64'hFFFF_FFFF);
      else begin
        logic [W-1:0] e;
        e = exp_b.pop_front();
        check("b_imm", out_imm_b, e[99:36]);
        check("b_fmt", 64'(out_fmt_b), 64'(e[35:33]));
        check("b_ill", 64'(out_illegal_b), 64'(e[32]));
        check("b_tag", 64'(out_tag_b), 64'(e[31:0]));
      end
    end
  end

  int exp_cnt[4] = '{1, 2, 3, 3};

  initial begin
    // reset values
    repeat (2) @(negedge clk);
    check("rst_out_valid", 64'(out_valid_a), 64'd0);
    check("rst_in_ready", 64'(in_ready_a), 64'd1);
    check("rst_out_imm", 64'(out_imm_a), 64'd0);
    check("rst_out_fmt", 64'(out_fmt_a), 64'd0);
    check("rst_out_ill", 64'(out_illegal_a), 64'd0);
    check("rst_out_tag", 64'(out_tag_a), 64'd0);
    check("rst_ill_cnt", 64'(illegal_cnt_a), 64'd0);
    check("rst_b_imm", out_imm_b, 64'd0);
    @(posedge clk); #1;
    rst_n = 1;
    idle(2);

    // XLEN 32 directed vectors; latency checked right after accepts
    push_a(32'hFFF00093, 32'd10, 64'hFFFF_FFFF, 3'b000, 1'b0);
    check("a_latency_addi", 64'(out_valid_a), 64'd1);
    push_a(32'hFE112E23, 32'd11, 64'hFFFF_FFFC, 3'b001, 1'b0);
    check("a_latency_sw", 64'(out_valid_a), 64'd1);
    push_a(32'h00509093, 32'd12, 64'd5, 3'b101, 1'b0);
    push_a(32'hFF9FF06F, 32'd13, 64'hFFFF_FFF8, 3'b011, 1'b0);
    push_a(32'hFE000EE3, 32'd14, 64'hFFFF_FFFC, 3'b010, 1'b0);
    push_a(32'h7FF02083, 32'd15, 64'h0000_07FF, 3'b000, 1'b0);
    push_a(32'h0FF0000F, 32'd16, 64'h0000_00FF, 3'b000, 1'b0);
    push_a(32'h4050D093, 32'd17, 64'd5, 3'b101, 1'b0);
    push_a(32'h02109093, 32'd18, 64'd1, 3'b101, 1'b0);
    push_a(32'h00001097, 32'd19, 64'h0000_1000, 3'b100, 1'b0);
    push_a(32'h800000B7, 32'd20, 64'h8000_0000, 3'b100, 1'b0);
    push_a(32'h002081B3, 32'd21, 64'd0, 3'b111, 1'b0);
`ifdef IMM_GEN_ZICSR_EN
    push_a(32'h3050D073, 32'd22, 64'd1, 3'b110, 1'b0);
`else
    push_a(32'h3050D073, 32'd22, 64'h0000_0305, 3'b000, 1'b0);
`endif

    // XLEN 64 directed vectors
    push_b(32'hFFF00093, 32'd30, 64'hFFFF_FFFF_FFFF_FFFF, 3'b000, 1'b0);
    push_b(32'h800000B7, 32'd31, 64'hFFFF_FFFF_8000_0000, 3'b100, 1'b0);
    push_b(32'h02109093, 32'd32, 64'd33, 3'b101, 1'b0);
    push_b(32'hFE112E23, 32'd33, 64'hFFFF_FFFF_FFFF_FFFC, 3'b001, 1'b0);
    push_b(32'h00001097, 32'd34, 64'h0000_0000_0000_1000, 3'b100, 1'b0);
    idle(3);

    // backpressure: two accepts fill the buffer, third waits for release
    out_ready_a = 0;
    fork
      begin
        push_a(32'h00100093, 32'd1, 64'd1, 3'b000, 1'b0);
        push_a(32'h00100093, 32'd2, 64'd1, 3'b000, 1'b0);
        push_a(32'h00100093, 32'd3, 64'd1, 3'b000, 1'b0);
      end
      begin
        repeat (4) @(posedge clk);
        #2;
        check("full_in_ready", 64'(in_ready_a), 64'd0);
        check("stall_valid", 64'(out_valid_a), 64'd1);
        check("stall_head_tag", 64'(out_tag_a), 64'd1);
        out_ready_a = 1;
      end
    join
    idle(4);

    // saturating illegal counter (CNT_W = 2)
    for (int i = 0; i < 4; i++) begin
      push_a(32'h00000000, 32'(40 + i), 64'd0, 3'b111, 1'b1);
      check("ill_cnt", 64'(illegal_cnt_a), 64'(exp_cnt[i]));
    end
    idle(4);

    // flush with concurrent illegal push on an empty buffer
    flush_a = 1; in_valid_a = 1; in_instr_a = 32'h00000000; in_tag_a = 32'd99;
    @(posedge clk); #1;
    flush_a = 0; in_valid_a = 0;
    check("flush_ill_cnt", 64'(illegal_cnt_a), 64'd3);
    check("flush_out_valid", 64'(out_valid_a), 64'd0);
    check("flush_in_ready", 64'(in_ready_a), 64'd1);

    // flush a full buffer, then confirm a fresh entry comes out cleanly
    out_ready_a = 0;
    raw_push_a(2);
    check("prefill_in_ready", 64'(in_ready_a), 64'd0);
    flush_a = 1;
    @(posedge clk); #1;
    flush_a = 0;
    check("flush_full_valid", 64'(out_valid_a), 64'd0);
    out_ready_a = 1;
    push_a(32'hFFF00093, 32'd50, 64'hFFFF_FFFF, 3'b000, 1'b0);
    idle(4);

    // asynchronous reset mid-cycle with a full buffer
    out_ready_a = 0;
    raw_push_a(2);
    #2 rst_n = 0;
    #1;
    check("arst_out_valid", 64'(out_valid_a), 64'd0);
    check("arst_in_ready", 64'(in_ready_a), 64'd1);
    check("arst_out_tag", 64'(out_tag_a), 64'd0);
    check("arst_ill_cnt", 64'(illegal_cnt_a), 64'd0);
    @(posedge clk); #1;
    rst_n = 1;
    out_ready_a = 1;
    idle(3);

    check("a_queue_drained", 64'(exp_a.size()), 64'd0);
    check("b_queue_drained", 64'(exp_b.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Pipelined, parametrised immediate generator for the decode stage. It decodes the immediate format directly from the opcode instead of taking an external `immsrc`, and sign-extends to XLEN (32 or 64). It adds a shift-amount format and a saturating illegal-opcode counter. Results pass through a 2-entry output buffer with valid/ready handshakes on both sides, so decode can stall without losing instructions.

## Interface
- `XLEN`, 32: datapath width; legal values 32 or 64.
- `TAG_W`, 32: width of the sideband tag (e.g. PC) carried alongside each instruction.
- `CNT_W`, 16: width of the illegal-opcode counter.

Ports:
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `flush` in 1: synchronous; empties the buffer.
- `in_valid` in 1: instruction present.
- `in_ready` out 1: buffer can accept.
- `in_instr` in 32: raw instruction word.
- `in_tag` in TAG_W: sideband, passed through unchanged.
- `out_valid` out 1: head entry valid.
- `out_ready` in 1: consumer takes the head entry.
- `out_imm` out XLEN: extended immediate.
- `out_fmt` out 3: format code.
- `out_illegal` out 1: opcode not recognised.
- `out_tag` out TAG_W: tag of the head entry.
- `illegal_cnt` out CNT_W: count of accepted illegal instructions.

## Operation
Format codes: 000 I, 001 S, 010 B, 011 J, 100 U, 101 SH (shift amount), 110 Z (CSR zimm), 111 none. Codes 000–100 keep the team's existing `immsrc` encoding.

Opcode `in_instr[6:0]` to format:
- 0000011 LOAD, 1100111 JALR, 0001111 MISC-MEM → I.
- 0010011 OP-IMM → SH if funct3 = 001 or 101, else I.
- 0100011 → S.
- 1100011 → B.
- 1101111 → J.
- 0110111 / 0010111 → U.
- 0110011 OP → none, imm = 0.
- 1110011 SYSTEM → see Configuration.
- Anything else, including `instr[1:0]` ≠ 11 → none, imm = 0, illegal = 1.

Extension rules, sign bit `instr[31]` replicated to XLEN:
- I: sext(`[31:20]`).
- S: sext(`{[31:25],[11:7]}`).
- B: sext(`{[31],[7],[30:25],[11:8],0}`).
- J: sext(`{[31],[19:12],[20],[30:21],0}`).
- U: sext(`{[31:12],12'b0}`). For XLEN = 64, bit 31 fills bits 63:32.
- SH: zext(`[24:20]`) when XLEN = 32; zext(`[25:20]`) when XLEN = 64.

Buffer behaviour:
- Decode is combinational on the input side. The decoded entry {imm, fmt, illegal, tag} is written into the 2-entry FIFO on accept (`in_valid && in_ready`).
- `in_ready` = count < 2. It is a function of registered state only; there is no combinational path from `out_ready`.
- Pop occurs on `out_valid && out_ready`. Push and pop in the same cycle at count 1 leaves count at 1.
- `flush`: count ← 0 and read/write pointers reset. Flush beats any same-cycle push or pop; the pushed entry is dropped and not counted.
- `illegal_cnt`: increments on each accepted entry with illegal = 1. It is not incremented on a flushed push and saturates at 2^CNT_W − 1. Flush does not clear it.

## Timing
- Reset values: `out_valid` 0, `in_ready` 1 (count 0), `out_imm` 0, `out_fmt` 000, `out_illegal` 0, `out_tag` 0, `illegal_cnt` 0.
- Latency: an entry accepted in cycle N into an empty buffer is presented with `out_valid` = 1 in cycle N+1.
- Throughput: 1 instruction per cycle while `out_ready` is held high.
- Order: FIFO order is preserved and pointers wrap modulo 2.
- Output stability: while `out_valid && !out_ready`, all `out_*` signals hold stable.
- Reset asserted mid-stream: buffer contents are discarded immediately and outputs return to their reset values asynchronously.

## Configuration
`IMM_GEN_ZICSR_EN`:
- Defined: SYSTEM with funct3 ≠ 000 → Z, imm = zext(`instr[19:15]`); SYSTEM with funct3 = 000 → I.
- Undefined: all SYSTEM instructions → I. Format code 110 is never produced.

## Test plan
- XLEN = 32, `in_instr` 0xFFF00093 (addi −1) → imm 0xFFFFFFFF, fmt 000. Then 0xFE112E23 (sw −4) → imm 0xFFFFFFFC, fmt 001, one cycle after accept.
- 0x00509093 (slli 5) → fmt 101, imm 5. 0xFF9FF06F (jal −8) → fmt 011, imm 0xFFFFFFF8.
- XLEN = 64, 0x800000B7 (lui 0x80000) → imm 0xFFFFFFFF80000000, fmt 100.
- Hold `out_ready` = 0, push 3 instructions with tags 1, 2, 3 → `in_ready` drops after 2 accepts. Release `out_ready` → tags emerge in order 1, 2, 3 with no loss.
- CNT_W = 2, push 0x00000000 four times → `out_illegal` = 1 each time, `illegal_cnt` reads 1, 2, 3, 3. Flush with a concurrent push of 0x00000000 → count stays 3 and the buffer is empty next cycle.
- With `IMM_GEN_ZICSR_EN` defined, 0x3050D073 (csrrwi, zimm = 1) → fmt 110, imm 1. Without it → fmt 000, imm 0x00000305.
